// File: rtl/phy_pkg.sv
`default_nettype none
// ============================================================================
// phy_pkg : line symbols and receiver state encoding shared across the phy
// Revision: 1.0
// ============================================================================
package phy_pkg;

    localparam logic [7:0] PHY_COM = 8'hBC;
    localparam logic [7:0] PHY_IDL = 8'h7C;

    localparam logic [1:0] RX_SEARCH = 2'd0;
    localparam logic [1:0] RX_ALIGN  = 2'd1;
    localparam logic [1:0] RX_LOCKED = 2'd2;

    typedef enum logic [1:0] {
        ST_SEARCH = RX_SEARCH,
        ST_ALIGN  = RX_ALIGN,
        ST_LOCKED = RX_LOCKED
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/serial_paralelo_rx_if.sv
`default_nettype none
// ============================================================================
// serial_paralelo_rx_if : serial lane input and recovered byte outputs
// Revision: 1.0
// ============================================================================
interface serial_paralelo_rx_if;

    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;
    logic       idle_out;

    modport master (
        output data_in,
        input  data_out,
        input  valid_out,
        input  active,
        input  idle_out
    );

    modport slave (
        input  data_in,
        output data_out,
        output valid_out,
        output active,
        output idle_out
    );

endinterface
`default_nettype wire

// File: rtl/serial_paralelo_rx.sv
`default_nettype none
// ============================================================================
// serial_paralelo_rx : COM-aligned serial-to-parallel byte receiver, one lane
// Revision: 1.0
// ============================================================================
module serial_paralelo_rx
    import phy_pkg::*;
#(
    parameter logic [7:0]  COM      = PHY_COM,
    parameter logic [7:0]  IDL      = PHY_IDL,
    parameter int unsigned BC_COUNT = 4
) (
    input wire logic            clk_32f,
    input wire logic            reset,
    serial_paralelo_rx_if.slave bus
);

    localparam logic [2:0] c_bc_lim = 3'(BC_COUNT);

    rx_state_t  r_state, w_state_n;
    // Only the seven most recent bits are kept; the eighth arrives on data_in.
    logic [6:0] r_sr;
    logic [2:0] r_cnt,   w_cnt_n;
    logic [2:0] r_bc,    w_bc_n;
    logic [7:0] r_data,  w_data_n;
    logic       r_valid, w_valid_n;
    logic       r_active, w_active_n;
    logic       r_idle,  w_idle_n;

    logic [7:0] w_nb;
    logic       w_boundary;

    assign w_nb       = {r_sr, bus.data_in};
    assign w_boundary = (r_cnt == 3'd7);

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_SEARCH;
            r_sr     <= '0;
            r_cnt    <= '0;
            r_bc     <= '0;
            r_data   <= 8'h00;
            r_valid  <= 1'b0;
            r_active <= 1'b0;
            r_idle   <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_sr     <= w_nb[6:0];
            r_cnt    <= w_cnt_n;
            r_bc     <= w_bc_n;
            r_data   <= w_data_n;
            r_valid  <= w_valid_n;
            r_active <= w_active_n;
            r_idle   <= w_idle_n;
        end
    end

    always_comb begin
        w_state_n  = r_state;
        w_cnt_n    = r_cnt + 3'd1;
        w_bc_n     = r_bc;
        w_data_n   = r_data;
        w_valid_n  = r_valid;
        w_active_n = r_active;
        w_idle_n   = r_idle;

        case (r_state)
            ST_SEARCH: begin
                // Sliding match: the edge that completes a COM becomes offset 0.
                w_cnt_n = 3'd0;
                if (w_nb == COM) begin
                    w_bc_n    = 3'd1;
                    w_state_n = ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                if (w_boundary) begin
                    if (w_nb == COM) begin
                        w_bc_n = (r_bc == c_bc_lim) ? r_bc : r_bc + 3'd1;
                        if (r_bc + 3'd1 == c_bc_lim) begin
                            w_state_n  = ST_LOCKED;
                            w_active_n = 1'b1;
                        end
                    end else begin
                        w_state_n = ST_SEARCH;
                        w_bc_n    = 3'd0;
                        w_cnt_n   = 3'd0;
                    end
                end
            end
            ST_LOCKED: begin
                if (w_boundary) begin
                    if (w_nb == COM) begin
                        w_valid_n = 1'b0;
                        w_idle_n  = 1'b0;
                    end else if (w_nb == IDL) begin
                        w_valid_n = 1'b0;
                        w_idle_n  = 1'b1;
                    end else begin
                        w_data_n  = w_nb;
                        w_valid_n = 1'b1;
                        w_idle_n  = 1'b0;
                    end
                end
            end
            default: begin
                w_state_n = ST_SEARCH;
                w_cnt_n   = 3'd0;
                w_bc_n    = 3'd0;
            end
        endcase
    end

    assign bus.data_out  = r_data;
    assign bus.valid_out = r_valid;
    assign bus.active    = r_active;
    assign bus.idle_out  = r_idle;

endmodule
`default_nettype wire

// File: tb/tb_serial_paralelo_rx.sv
`default_nettype none
// ============================================================================
// tb_serial_paralelo_rx : directed and random lane streams against a byte-level model
// Revision: 1.0
// ============================================================================
module tb_serial_paralelo_rx;

    localparam logic [7:0] COM      = 8'hBC;
    localparam logic [7:0] IDL      = 8'h7C;
    localparam int         BC_COUNT = 4;

    logic clk_32f;
    logic reset;
    int   checks = 0;
    int   passes = 0;

    serial_paralelo_rx_if bus ();

    serial_paralelo_rx #(
        .COM      (COM),
        .IDL      (IDL),
        .BC_COUNT (BC_COUNT)
    ) dut (
        .clk_32f (clk_32f),
        .reset   (reset),
        .bus     (bus)
    );

    initial clk_32f = 1'b0;
    always #5 clk_32f = ~clk_32f;

    // Model: edge count since release, the edge where the current alignment
    // started (-1 while hunting), and how many aligned COMs have been seen.
    logic [7:0] m_last8;
    int         m_n;
    int         m_anchor;
    int         m_run;
    bit         m_locked;
    logic [7:0] m_data;
    logic       m_valid, m_active, m_idle;

    task automatic model_reset();
        m_last8  = 8'h00;
        m_n      = 0;
        m_anchor = -1;
        m_run    = 0;
        m_locked = 0;
        m_data   = 8'h00;
        m_valid  = 1'b0;
        m_active = 1'b0;
        m_idle   = 1'b0;
    endtask

    task automatic model_step(input logic b);
        m_n     = m_n + 1;
        m_last8 = {m_last8[6:0], b};
        if (m_anchor < 0) begin
            if (m_last8 == COM) begin
                m_anchor = m_n;
                m_run    = 1;
            end
        end else if (((m_n - m_anchor) % 8) == 0) begin
            if (m_locked) begin
                if (m_last8 == COM) begin
                    m_valid = 1'b0; m_idle = 1'b0;
                end else if (m_last8 == IDL) begin
                    m_valid = 1'b0; m_idle = 1'b1;
                end else begin
                    m_data = m_last8; m_valid = 1'b1; m_idle = 1'b0;
                end
            end else if (m_last8 == COM) begin
                m_run = m_run + 1;
                if (m_run == BC_COUNT) begin
                    m_locked = 1;
                    m_active = 1'b1;
                end
            end else begin
                m_anchor = -1;
                m_run    = 0;
            end
        end
    endtask

    task automatic pin(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks = checks + 1;
        if (got === exp) passes = passes + 1;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // Per-edge comparison of all outputs against the model.
    always @(posedge clk_32f) begin
        logic b;
        b = bus.data_in;
        #1;
        if (!reset) model_reset();
        else        model_step(b);
        checks = checks + 1;
        if ({bus.data_out, bus.valid_out, bus.active, bus.idle_out} ===
            {m_data, m_valid, m_active, m_idle})
            passes = passes + 1;
        else
            $display("FAIL cycle edge=%0d: got data=%h v=%b a=%b i=%b expected data=%h v=%b a=%b i=%b",
                     m_n, bus.data_out, bus.valid_out, bus.active, bus.idle_out,
                     m_data, m_valid, m_active, m_idle);
    end

    task automatic send_bit(input logic b);
        @(negedge clk_32f);
        bus.data_in = b;
        @(posedge clk_32f);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_byte_but_last(input logic [7:0] v);
        for (int i = 7; i >= 1; i--) send_bit(v[i]);
    endtask

    task automatic do_reset();
        @(negedge clk_32f);
        reset       = 1'b0;
        bus.data_in = 1'b0;
        repeat (2) @(posedge clk_32f);
        #2;
        reset = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] v;
        reset       = 1'b0;
        bus.data_in = 1'b0;

        // Lock at offset 0
        do_reset();
        pin("reset_data", bus.data_out, 8'h00);
        pin("reset_flags", {5'd0, bus.valid_out, bus.active, bus.idle_out}, 8'h00);
        repeat (3) send_byte(COM);
        send_byte_but_last(COM);
        pin("off0_active_edge31", {7'd0, bus.active}, 8'h00);
        send_bit(COM[0]);
        pin("off0_active_edge32", {7'd0, bus.active}, 8'h01);
        pin("off0_valid", {7'd0, bus.valid_out}, 8'h00);

        // Lock at offset 3, then first data byte
        do_reset();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        repeat (3) send_byte(COM);
        send_byte_but_last(COM);
        pin("off3_active_edge34", {7'd0, bus.active}, 8'h00);
        send_bit(COM[0]);
        pin("off3_active_edge35", {7'd0, bus.active}, 8'h01);
        send_byte(8'h5A);
        pin("off3_data", bus.data_out, 8'h5A);
        pin("off3_valid", {7'd0, bus.valid_out}, 8'h01);
        send_byte_but_last(8'h33);
        pin("off3_data_held", bus.data_out, 8'h5A);
        send_bit(1'b1);
        pin("off3_next_data", bus.data_out, 8'h33);

        // Broken training
        do_reset();
        send_byte(COM); send_byte(COM); send_byte(8'h12);
        repeat (3) send_byte(COM);
        send_byte_but_last(COM);
        pin("broken_active_before", {7'd0, bus.active}, 8'h00);
        send_bit(COM[0]);
        pin("broken_active_after", {7'd0, bus.active}, 8'h01);

        // Filler and idle after lock
        send_byte(8'hA5);
        pin("fill_a5", {bus.valid_out, bus.idle_out, 6'd0}, 8'h80);
        pin("fill_a5_data", bus.data_out, 8'hA5);
        send_byte(COM);
        pin("fill_com", {bus.valid_out, bus.idle_out, 6'd0}, 8'h00);
        pin("fill_com_data", bus.data_out, 8'hA5);
        send_byte(IDL);
        pin("fill_idl", {bus.valid_out, bus.idle_out, 6'd0}, 8'h40);
        send_byte(8'h3C);
        pin("fill_3c", {bus.valid_out, bus.idle_out, 6'd0}, 8'h80);
        pin("fill_3c_data", bus.data_out, 8'h3C);

        // Reset mid data byte while locked
        v = 8'h96;
        for (int i = 7; i >= 4; i--) send_bit(v[i]);
        #1 reset = 1'b0;
        #1;
        pin("midreset_data", bus.data_out, 8'h00);
        pin("midreset_flags", {5'd0, bus.valid_out, bus.active, bus.idle_out}, 8'h00);
        repeat (2) @(posedge clk_32f);
        #2 reset = 1'b1;
        repeat (3) send_byte(COM);
        send_byte_but_last(COM);
        pin("relock_before", {6'd0, bus.valid_out, bus.active}, 8'h00);
        send_bit(COM[0]);
        pin("relock_after", {6'd0, bus.valid_out, bus.active}, 8'h01);
        send_byte(8'h81);
        pin("relock_data", {bus.data_out}, 8'h81);

        // Randomized streams, checked every edge by the model
        for (int r = 0; r < 8; r++) begin
            int junk;
            do_reset();
            junk = $urandom_range(0, 15);
            for (int j = 0; j < junk; j++) send_bit(1'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                send_byte(COM);
                send_byte(8'($urandom));
            end
            repeat (BC_COUNT) send_byte(COM);
            for (int k = 0; k < 40; k++) begin
                case ($urandom_range(0, 7))
                    0:       send_byte(COM);
                    1:       send_byte(IDL);
                    default: send_byte(8'($urandom));
                endcase
                if ($urandom_range(0, 39) == 0) send_bit(1'($urandom));
            end
        end

        @(negedge clk_32f);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_paralelo_rx.md
# serial_paralelo_rx

Serial-to-parallel receiver for one phy lane. Consumes the MSB-first bit stream produced by the lane's parallel-to-serial transmitter on `clk_32f`, finds byte alignment from the COM (0xBC) training pattern, and reassembles 8-bit bytes with a valid flag. It sits directly downstream of the serializer and feeds the byte un-striping logic that drives `out0_rx`..`out3_rx`.

## Interface
- `COM`, default 8'hBC: alignment/filler symbol; marks the lane as not valid.
- `IDL`, default 8'h7C: idle symbol.
- `BC_COUNT`, default 4: consecutive aligned COMs required to lock; legal range 2..7.
- `clk_32f` in 1: bit clock, one serial bit per rising edge.
- `reset` in 1: asynchronous, active-low; 0 clears all state immediately.
- `data_in` in 1: serial bit, sampled on each rising edge; MSB of each byte first.
- `data_out` out 8: last received non-COM, non-IDL byte.
- `valid_out` out 1: `data_out` holds a valid byte for the current byte period.
- `active` out 1: receiver is locked; sticky until reset.
- `idle_out` out 1: last byte received while locked was IDL.

## Operation
- Shift register `sr[7:0]` loads `{sr[6:0], data_in}` on every edge. `nb` is the next byte, equal to `{sr[6:0], data_in}`.
- Bit counter `cnt[2:0]` runs 0..7 and wraps from 7 to 0. A byte boundary is an edge where `cnt==7`.
- The state machine has three states: SEARCH, ALIGN and LOCKED.
- SEARCH (state after reset):
  - `nb` is compared with COM on every edge, so the match slides over any bit offset.
  - On a match: `cnt<=0`, `bc_cnt<=1`, go to ALIGN.
  - With no match, `cnt` is don't-care and held at 0.
- ALIGN: `nb` is checked only at boundaries.
  - If `nb==COM`: `bc_cnt<=bc_cnt+1`. When the new count equals BC_COUNT: go to LOCKED and set `active<=1`.
  - If `nb!=COM`: go to SEARCH, `bc_cnt<=0`, `cnt<=0`. No sliding re-check of `nb` happens on that edge.
- LOCKED: `nb` is classified only at boundaries.
  - `nb==COM`: `valid_out<=0`, `idle_out<=0`, `data_out` held.
  - `nb==IDL`: `valid_out<=0`, `idle_out<=1`, `data_out` held.
  - Any other byte: `data_out<=nb`, `valid_out<=1`, `idle_out<=0`.
  - All outputs are held between boundaries.
  - LOCKED is left only by reset. No loss-of-lock detection; a misaligned stream yields garbage bytes, not a re-search.
- `bc_cnt` is 3 bits and saturates at BC_COUNT. It is not used in LOCKED.
- Reset values: `data_out=8'h00`, `valid_out=0`, `active=0`, `idle_out=0`, `sr=0`, `cnt=0`, `bc_cnt=0`, state SEARCH.

## Timing
- All outputs are registered and change only on rising `clk_32f` edges or on `reset` assertion.
- Latency: the last bit (LSB) of a byte is sampled at edge N. `data_out`/`valid_out` reflect that byte immediately after edge N and hold for exactly 8 edges.
- `active` rises at the edge sampling the LSB of the BC_COUNT-th consecutive COM.
  - Minimum from reset release: 8·BC_COUNT edges of an aligned COM stream, i.e. 32 edges for the default.
  - The first data byte can appear 8 edges later.
- A COM straddling a sliding match in SEARCH is accepted on the exact edge its LSB arrives, so alignment is fixed with 0-cycle slip.
- Reset asserted mid-byte or while LOCKED:
  - Outputs clear asynchronously, with no wait for a clock edge.
  - After release, the first edge samples normally in SEARCH.
- At a boundary, a COM on `nb` in ALIGN when `bc_cnt==BC_COUNT-1` transitions to LOCKED. It is not classified as data, so `valid_out` stays 0.

## Structure
- Shared package `phy_pkg` holds:
  - constants `PHY_COM=8'hBC` and `PHY_IDL=8'h7C`, used as the default values of COM and IDL;
  - a localparam state encoding `RX_SEARCH=2'd0`, `RX_ALIGN=2'd1`, `RX_LOCKED=2'd2`.
  - The transmitter uses the same constants.
- Single module, no sub-modules: shift register, two counters and the FSM fit in about 150 lines.
- The phy instantiates four copies, one per lane. A synthesized netlist must match RTL outputs cycle-for-cycle in the existing dual-model bench.

## Test plan
- **Lock at offset 0:** reset low 2 edges, then 4×0xBC. `active` rises at edge 32 after release; `valid_out` stays 0.
- **Lock at offset 3:** 3 junk bits `101`, then 4×0xBC, then 0x5A. `active` rises at edge 35. Then `data_out=8'h5A`, `valid_out=1` after edge 43, held 8 edges.
- **Broken training:** 0xBC,0xBC,0x12,0xBC,0xBC,0xBC,0xBC. Return to SEARCH after the 3rd byte; `active` rises only after the final 0xBC.
- **Filler/idle handling after lock:** 0xA5, 0xBC, 0x7C, 0x3C. Observe per byte period:
  - 0xA5: `valid_out=1`, `data_out=8'hA5`.
  - 0xBC: `valid_out=0`, `data_out=8'hA5` held.
  - 0x7C: `idle_out=1`, `valid_out=0`.
  - 0x3C: `valid_out=1`, `data_out=8'h3C`, `idle_out=0`.
- **Reset mid-operation:** assert reset at edge 4 of a data byte while LOCKED. All outputs are 0 before the next edge. The 4-COM relock sequence must be repeated before any `valid_out`.
